// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

  localparam logic [2:0] F3_WORD = 3'b010;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive denied fetch cycles; raises o_force_if at the limit.
module mem_arb_starve_ctr #(
  parameter int unsigned P_STARVE_LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_if_req,
  input  logic i_if_gnt,
  output logic o_force_if
);

  localparam int unsigned LP_W = $clog2(P_STARVE_LIMIT + 1);
  localparam logic [LP_W-1:0] LP_LIMIT = LP_W'(P_STARVE_LIMIT);

  logic [LP_W-1:0] r_cnt;
  logic [LP_W-1:0] w_cnt_d;

  always_comb begin
    w_cnt_d = r_cnt;
    if (!i_if_req || i_if_gnt) begin
      w_cnt_d = '0;
    end else if (r_cnt != LP_LIMIT) begin
      w_cnt_d = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign o_force_if = i_if_req && (r_cnt == LP_LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store with a fetch starvation guard.
// Optional perf counters are enabled by defining MEM_ARB_PERF_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH   = 32,
  parameter int unsigned P_ADDR_WIDTH   = 11,
  parameter int unsigned P_STARVE_LIMIT = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_if_req,
  input  logic [P_ADDR_WIDTH-1:0] i_if_addr,
  output logic                    o_if_gnt,
  output logic                    o_if_rvalid,
  output logic [P_DATA_WIDTH-1:0] o_if_rdata,
  input  logic                    i_ls_req,
  input  logic                    i_ls_we,
  input  logic [P_ADDR_WIDTH-1:0] i_ls_addr,
  input  logic [P_DATA_WIDTH-1:0] i_ls_wdata,
  input  logic [2:0]              i_ls_f3,
  output logic                    o_ls_gnt,
  output logic                    o_ls_rvalid,
  output logic [P_DATA_WIDTH-1:0] o_ls_rdata,
  output logic                    o_mem_en,
  output logic                    o_mem_we,
  output logic [P_ADDR_WIDTH-1:0] o_mem_addr,
  output logic [P_DATA_WIDTH-1:0] o_mem_wdata,
  output logic [2:0]              o_mem_f3,
  input  logic [P_DATA_WIDTH-1:0] i_mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]             o_perf_conflicts,
  output logic [31:0]             o_perf_if_starved
`endif
);

  logic                    w_force_if;
  logic                    w_if_gnt;
  logic                    w_ls_gnt;
  logic                    w_mem_en;
  owner_e                  r_owner;
  owner_e                  w_owner_d;
  logic [P_ADDR_WIDTH-1:0] r_mem_addr;
  logic [P_DATA_WIDTH-1:0] r_mem_wdata;
  logic [2:0]              r_mem_f3;
  logic [P_ADDR_WIDTH-1:0] w_addr;
  logic [P_DATA_WIDTH-1:0] w_wdata;
  logic [2:0]              w_f3;
  logic                    w_we;

  mem_arb_starve_ctr #(
    .P_STARVE_LIMIT (P_STARVE_LIMIT)
  ) u_starve_ctr (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_if_req   (i_if_req),
    .i_if_gnt   (w_if_gnt),
    .o_force_if (w_force_if)
  );

  // Load/store is the older instruction, so it wins unless fetch has starved too long.
  always_comb begin
    w_if_gnt  = i_if_req && (!i_ls_req || w_force_if);
    w_ls_gnt  = i_ls_req && !w_if_gnt;
    w_mem_en  = w_if_gnt || w_ls_gnt;
    w_owner_d = OWN_NONE;
    if (w_if_gnt) begin
      w_owner_d = OWN_IF;
    end else if (w_ls_gnt) begin
      w_owner_d = OWN_LS;
    end
  end

  // Idle cycles replay the last address/data so the macro inputs don't toggle needlessly.
  always_comb begin
    w_addr  = r_mem_addr;
    w_wdata = r_mem_wdata;
    w_f3    = r_mem_f3;
    w_we    = 1'b0;
    if (w_if_gnt) begin
      w_addr = i_if_addr;
      w_f3   = F3_WORD;
    end else if (w_ls_gnt) begin
      w_addr  = i_ls_addr;
      w_wdata = i_ls_wdata;
      w_we    = i_ls_we;
      w_f3    = i_ls_f3;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owner     <= OWN_NONE;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_f3    <= '0;
    end else begin
      r_owner     <= w_owner_d;
      r_mem_addr  <= w_addr;
      r_mem_wdata <= w_wdata;
      r_mem_f3    <= w_f3;
    end
  end

  assign o_if_gnt    = w_if_gnt;
  assign o_ls_gnt    = w_ls_gnt;
  assign o_mem_en    = w_mem_en;
  assign o_mem_we    = w_we;
  assign o_mem_addr  = w_addr;
  assign o_mem_wdata = w_wdata;
  assign o_mem_f3    = w_f3;

  assign o_if_rvalid = (r_owner == OWN_IF);
  assign o_ls_rvalid = (r_owner == OWN_LS);
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
  assign o_ls_rdata  = o_ls_rvalid ? i_mem_rdata : '0;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] r_perf_conflicts;
  logic [31:0] r_perf_if_starved;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perf_conflicts  <= '0;
      r_perf_if_starved <= '0;
    end else begin
      if (i_if_req && i_ls_req && (r_perf_conflicts != '1)) begin
        r_perf_conflicts <= r_perf_conflicts + 32'd1;
      end
      if (i_if_req && !w_if_gnt && (r_perf_if_starved != '1)) begin
        r_perf_if_starved <= r_perf_if_starved + 32'd1;
      end
    end
  end

  assign o_perf_conflicts  = r_perf_conflicts;
  assign o_perf_if_starved = r_perf_if_starved;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a behavioural memory and reference model.
module tb_mem_port_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 11;
  localparam int LIM = 4;
  localparam int MEM_WORDS = 2048;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_if_req;
  logic [AW-1:0] i_if_addr;
  logic          o_if_gnt, o_if_rvalid;
  logic [DW-1:0] o_if_rdata;
  logic          i_ls_req, i_ls_we;
  logic [AW-1:0] i_ls_addr;
  logic [DW-1:0] i_ls_wdata;
  logic [2:0]    i_ls_f3;
  logic          o_ls_gnt, o_ls_rvalid;
  logic [DW-1:0] o_ls_rdata;
  logic          o_mem_en, o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [2:0]    o_mem_f3;
  logic [DW-1:0] mem_rdata;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]   o_perf_conflicts, o_perf_if_starved;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .P_DATA_WIDTH   (DW),
    .P_ADDR_WIDTH   (AW),
    .P_STARVE_LIMIT (LIM)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_if_req    (i_if_req),
    .i_if_addr   (i_if_addr),
    .o_if_gnt    (o_if_gnt),
    .o_if_rvalid (o_if_rvalid),
    .o_if_rdata  (o_if_rdata),
    .i_ls_req    (i_ls_req),
    .i_ls_we     (i_ls_we),
    .i_ls_addr   (i_ls_addr),
    .i_ls_wdata  (i_ls_wdata),
    .i_ls_f3     (i_ls_f3),
    .o_ls_gnt    (o_ls_gnt),
    .o_ls_rvalid (o_ls_rvalid),
    .o_ls_rdata  (o_ls_rdata),
    .o_mem_en    (o_mem_en),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_f3    (o_mem_f3),
    .i_mem_rdata (mem_rdata)
`ifdef MEM_ARB_PERF_EN
    ,
    .o_perf_conflicts  (o_perf_conflicts),
    .o_perf_if_starved (o_perf_if_starved)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  function automatic logic [DW-1:0] init_word(input int a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Behavioural single-port memory with one-cycle read latency.
  logic          mem_clr;
  logic [DW-1:0] env_mem [MEM_WORDS];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_clr) begin
      for (int i = 0; i < MEM_WORDS; i++) env_mem[i] <= init_word(i);
      mem_rdata <= '0;
    end else if (o_mem_en) begin
      if (o_mem_we) env_mem[o_mem_addr] <= o_mem_wdata;
      mem_rdata <= env_mem[o_mem_addr];
    end
  end

  // Reference model state
  typedef struct {
    bit            is_if;
    bit            is_store;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] model_mem [MEM_WORDS];
  int            m_starve, m_conf, m_starved;

  bit            d_if_req, d_ls_req, d_ls_we;
  logic [AW-1:0] d_if_addr, d_ls_addr;
  logic [DW-1:0] d_ls_wdata;
  logic [2:0]    d_ls_f3;
  bit            g_if, g_ls;

  task automatic step();
    bit e_if, e_ls;
    @(negedge clk);
    #1;
    i_if_req   = d_if_req;
    i_if_addr  = d_if_addr;
    i_ls_req   = d_ls_req;
    i_ls_we    = d_ls_we;
    i_ls_addr  = d_ls_addr;
    i_ls_wdata = d_ls_wdata;
    i_ls_f3    = d_ls_f3;
    #1;
    e_if = d_if_req && (!d_ls_req || m_starve >= LIM);
    e_ls = d_ls_req && !e_if;
    check("if_gnt", 64'(o_if_gnt), 64'(e_if));
    check("ls_gnt", 64'(o_ls_gnt), 64'(e_ls));
    check("mem_en", 64'(o_mem_en), 64'(e_if || e_ls));
    if (e_if) begin
      check("if_mem_addr", 64'(o_mem_addr), 64'(d_if_addr));
      check("if_mem_we", 64'(o_mem_we), 64'd0);
      check("if_mem_f3", 64'(o_mem_f3), 64'd2);
      q.push_back('{is_if: 1'b1, is_store: 1'b0, data: model_mem[d_if_addr], due: cyc + 1});
    end else if (e_ls) begin
      check("ls_mem_addr", 64'(o_mem_addr), 64'(d_ls_addr));
      check("ls_mem_we", 64'(o_mem_we), 64'(d_ls_we));
      check("ls_mem_f3", 64'(o_mem_f3), 64'(d_ls_f3));
      if (d_ls_we) check("ls_mem_wdata", 64'(o_mem_wdata), 64'(d_ls_wdata));
      q.push_back('{is_if: 1'b0, is_store: d_ls_we, data: model_mem[d_ls_addr], due: cyc + 1});
      if (d_ls_we) model_mem[d_ls_addr] = d_ls_wdata;
    end else begin
      check("idle_mem_we", 64'(o_mem_we), 64'd0);
    end
    if (d_if_req && d_ls_req) m_conf++;
    if (d_if_req && !e_if) m_starved++;
    if (!d_if_req || e_if) m_starve = 0;
    else if (m_starve < LIM) m_starve++;
    g_if = e_if;
    g_ls = e_ls;
  endtask

  // Monitor: pops the scoreboard whenever a response is due and compares both ports.
  bit            mon_en = 1'b0;
  bit            ev_if, ev_ls, ev_st;
  logic [DW-1:0] ev_data;
  exp_t          ev;

  always @(negedge clk) begin
    if (mon_en) begin
      ev_if = 1'b0;
      ev_ls = 1'b0;
      ev_st = 1'b0;
      ev_data = '0;
      if (q.size() > 0 && q[0].due <= cyc) begin
        ev = q.pop_front();
        if (ev.due < cyc) check("resp_late_entry", 64'(ev.due), 64'(cyc));
        ev_if = ev.is_if;
        ev_ls = !ev.is_if;
        ev_st = ev.is_store;
        ev_data = ev.data;
      end
      check("if_rvalid", 64'(o_if_rvalid), 64'(ev_if));
      check("ls_rvalid", 64'(o_ls_rvalid), 64'(ev_ls));
      check("if_rdata", 64'(o_if_rdata), ev_if ? 64'(ev_data) : 64'd0);
      if (!ev_st) check("ls_rdata", 64'(o_ls_rdata), ev_ls ? 64'(ev_data) : 64'd0);
    end
  end

  task automatic new_if(input int pct);
    d_if_req  = ($urandom_range(0, 99) < pct);
    d_if_addr = AW'($urandom_range(0, 63));
  endtask

  task automatic new_ls(input int pct);
    d_ls_req   = ($urandom_range(0, 99) < pct);
    d_ls_we    = $urandom_range(0, 2) == 0;
    d_ls_addr  = AW'($urandom_range(0, 63));
    d_ls_wdata = $urandom;
    d_ls_f3    = 3'($urandom_range(0, 7));
  endtask

  task automatic clear_reqs();
    d_if_req = 1'b0; d_if_addr = '0;
    d_ls_req = 1'b0; d_ls_we = 1'b0; d_ls_addr = '0; d_ls_wdata = '0; d_ls_f3 = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_clr = 1'b1;
    i_if_req = 1'b0; i_if_addr = '0; i_ls_req = 1'b0; i_ls_we = 1'b0;
    i_ls_addr = '0; i_ls_wdata = '0; i_ls_f3 = '0;
    clear_reqs();
    m_starve = 0; m_conf = 0; m_starved = 0;
    for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = init_word(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_clr = 1'b0;
    check("rst_if_gnt", 64'(o_if_gnt), 64'd0);
    check("rst_ls_gnt", 64'(o_ls_gnt), 64'd0);
    check("rst_if_rvalid", 64'(o_if_rvalid), 64'd0);
    check("rst_ls_rvalid", 64'(o_ls_rvalid), 64'd0);
    check("rst_mem_en", 64'(o_mem_en), 64'd0);
    check("rst_mem_addr", 64'(o_mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(o_mem_wdata), 64'd0);
    check("rst_mem_f3", 64'(o_mem_f3), 64'd0);
    rst_n = 1'b1;
    #1 mon_en = 1'b1;

    // Fetch-only stream
    for (int k = 0; k < 4; k++) begin
      d_if_req = 1'b1; d_if_addr = AW'(k * 4);
      step();
    end
    clear_reqs();
    step();

    // Store then load of the same word
    d_ls_req = 1'b1; d_ls_we = 1'b1; d_ls_addr = 11'h040; d_ls_wdata = 32'hDEAD_BEEF;
    d_ls_f3 = 3'b010;
    step();
    d_ls_we = 1'b0;
    step();
    clear_reqs();
    step();
    step();

    // Continuous conflict: LS,LS,LS,LS,IF repeating
    for (int k = 0; k < 15; k++) begin
      d_if_req = 1'b1; d_ls_req = 1'b1; d_ls_we = 1'b0;
      if (k == 0) begin d_if_addr = 11'h100; d_ls_addr = 11'h200; d_ls_f3 = 3'b010; end
      step();
      check("conflict_pattern_if", 64'(g_if), 64'((k % 5) == 4));
      if (g_if) d_if_addr = d_if_addr + 11'd4;
      if (g_ls) d_ls_addr = d_ls_addr + 11'd4;
    end
    clear_reqs();
    step();

    // Interleaved single-cycle owners
    for (int k = 0; k < 8; k++) begin
      clear_reqs();
      if (k % 2 == 0) begin d_if_req = 1'b1; d_if_addr = AW'(k + 16); end
      else begin d_ls_req = 1'b1; d_ls_addr = AW'(k + 32); d_ls_f3 = 3'b000; end
      step();
    end
    clear_reqs();

    // Randomized traffic under the request-hold rule
    for (int k = 0; k < 400; k++) begin
      step();
      if (g_if || !d_if_req) new_if(60);
      if (g_ls || !d_ls_req) new_ls(60);
    end
    clear_reqs();
    step();
    step();

    // Asynchronous reset right after a load grant
    d_ls_req = 1'b1; d_ls_we = 1'b0; d_ls_addr = 11'h040; d_ls_f3 = 3'b010;
    step();
    #1;
    mon_en = 1'b0;
    rst_n = 1'b0;
    clear_reqs();
    i_if_req = 1'b0; i_ls_req = 1'b0;
    #1;
    check("async_rst_ls_gnt", 64'(o_ls_gnt), 64'd0);
    check("async_rst_mem_en", 64'(o_mem_en), 64'd0);
    check("async_rst_mem_addr", 64'(o_mem_addr), 64'd0);
    check("async_rst_mem_wdata", 64'(o_mem_wdata), 64'd0);
    @(posedge clk);
    #1;
    check("async_rst_ls_rvalid", 64'(o_ls_rvalid), 64'd0);
    check("async_rst_ls_rdata", 64'(o_ls_rdata), 64'd0);
    q.delete();
    m_starve = 0; m_conf = 0; m_starved = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 mon_en = 1'b1;
    repeat (3) step();

`ifdef MEM_ARB_PERF_EN
    for (int k = 0; k < 10; k++) begin
      d_if_req = 1'b1; d_ls_req = 1'b1; d_ls_we = 1'b0;
      d_if_addr = AW'(k); d_ls_addr = AW'(k + 8); d_ls_f3 = 3'b010;
      step();
    end
    @(negedge clk);
    check("perf_conflicts", 64'(o_perf_conflicts), 64'(m_conf));
    check("perf_if_starved", 64'(o_perf_if_starved), 64'(m_starved));
    check("perf_conflicts_10", 64'(o_perf_conflicts), 64'd10);
    check("perf_if_starved_8", 64'(o_perf_if_starved), 64'd8);
    clear_reqs();
    step();
`endif

    repeat (3) step();
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the core's instruction-fetch port and its load/store port, for a unified-memory build of the pipelined RISC-V top.
- Sits between riscv_core and a single memory macro.
- Arbitrates each cycle and forwards the winner's request to memory.
- Tracks which requester owns the in-flight read and routes the 1-cycle-latency read data back, with a starvation guard for fetch.

Parameters:
- P_DATA_WIDTH, 32, data bus width.
- P_ADDR_WIDTH, 11, memory address width (shared by both requesters).
- P_STARVE_LIMIT, 4, consecutive denied fetch cycles after which fetch is forced to win.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_if_req  in  1  fetch request.
- i_if_addr  in  P_ADDR_WIDTH  fetch address.
- o_if_gnt  out  1  fetch accepted this cycle.
- o_if_rvalid  out  1  fetch data valid.
- o_if_rdata  out  P_DATA_WIDTH  fetch data.
- i_ls_req  in  1  load/store request.
- i_ls_we  in  1  1 = store.
- i_ls_addr  in  P_ADDR_WIDTH  load/store address.
- i_ls_wdata  in  P_DATA_WIDTH  store data.
- i_ls_f3  in  3  funct3 size/sign code, passed to memory.
- o_ls_gnt  out  1  load/store accepted this cycle.
- o_ls_rvalid  out  1  load data valid, or store ack.
- o_ls_rdata  out  P_DATA_WIDTH  load data.
- o_mem_en  out  1  memory access strobe.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  P_ADDR_WIDTH  memory address.
- o_mem_wdata  out  P_DATA_WIDTH  memory write data.
- o_mem_f3  out  3  memory funct3.
- i_mem_rdata  in  P_DATA_WIDTH  memory read data, valid one cycle after o_mem_en.

Behaviour:
- Clock and reset: single clock i_clk; i_rst_n is asynchronous, active-low.
- Reset values: all registered state and all outputs are 0; owner = OWN_NONE; starve count = 0.
- Grants: combinational, same cycle as the request. At most one of o_if_gnt / o_ls_gnt is high per cycle.
- Priority:
  - Load/store wins by default (older instruction in the pipeline).
  - If the starve count equals P_STARVE_LIMIT and i_if_req is high, fetch wins.
- Memory drive:
  - o_mem_en = o_if_gnt | o_ls_gnt.
  - Address, wdata, we and f3 are muxed from the winner.
  - Fetch forces we = 0 and f3 = 3'b010 (word).
  - With no grant, o_mem_we = 0 and the other memory outputs hold their last value (don't care).
- Starve counter:
  - Increments (saturating at P_STARVE_LIMIT) when i_if_req is high and o_if_gnt is low.
  - Clears on o_if_gnt, or when i_if_req is low.
- Owner register: on a grant, loads OWN_IF or OWN_LS for the next cycle; otherwise loads OWN_NONE.
- Response, exactly one cycle after grant:
  - OWN_IF: o_if_rvalid = 1, o_if_rdata = i_mem_rdata.
  - OWN_LS: o_ls_rvalid = 1, o_ls_rdata = i_mem_rdata. A store also raises rvalid, and its rdata is don't care.
  - rdata outputs are zero whenever the matching rvalid is 0.
- Pipelining: back-to-back grants are allowed every cycle; throughput is 1 access per cycle, read latency 1.
- Request hold rule: a requester holds req/addr/data stable until it sees gnt. The arbiter does not latch ungranted requests.
- Simultaneous request with starve count < limit: LS granted, IF counted as starved.
- Simultaneous request with starve count = limit: IF granted, counter cleared; LS waits one cycle.
- Reset mid-access: the owner clears immediately, so the in-flight rvalid is lost. Requesters reissue after reset.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined:
  - Adds 32-bit saturating counters o_perf_conflicts (cycles with both requests high) and o_perf_if_starved (cycles fetch was denied).
  - Both counters reset to 0.
- When undefined: those ports and registers are absent.

Decomposition:
- Package mem_arb_pkg:
  - owner_e enum (OWN_NONE, OWN_IF, OWN_LS), 2 bits.
  - Constant F3_WORD = 3'b010.
- One sub-module, mem_arb_starve_ctr: the saturating starve counter plus its force-fetch output.
- The grant mux and owner register stay in the top module.

Test Plan:
- IF-only stream: i_if_req = 1 for 4 cycles at addresses 0x000/0x004/0x008/0x00C, memory preloaded → o_if_gnt high each cycle; o_if_rvalid high cycles 1..4 with matching words; o_ls_* idle.
- Store then load: LS we = 1, addr 0x040, wdata 0xDEADBEEF, f3 = 010; next cycle load 0x040 → store ack rvalid, then o_ls_rdata = 0xDEADBEEF one cycle after the load grant.
- Conflict: both requests held continuously, P_STARVE_LIMIT = 4 → grant pattern LS,LS,LS,LS,IF repeating; IF never waits more than 4 cycles.
- Interleaved owner routing: alternating single-cycle IF and LS loads with distinct data → each rvalid/rdata goes to the correct port; the other port's rvalid stays 0.
- Async reset mid-read: assert i_rst_n = 0 right after an LS load grant, between clock edges → all outputs 0 immediately; no rvalid after release.
- MEM_ARB_PERF_EN defined: 10 cycles of both requests → o_perf_conflicts = 10, o_perf_if_starved = 8.
